// File: rtl/p_perm_stream.sv
// p_perm_stream: DES P-box permutation on a valid/ready stream.
//
// Each beat carries LANES independent 32-bit words. Stage 0 applies the forward
// DES P permutation (in_inv = 0) or its inverse (in_inv = 1) to every lane; the
// remaining PIPE_STAGES-1 stages only carry data, mode and valid. Every stage
// advances when it is empty or its downstream stage advances, so the pipeline
// sustains one beat per cycle and stalls losslessly under backpressure.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset; drops all in-flight beats
//   in_valid   input beat present
//   in_ready   block accepts a beat this cycle
//   in_data    input words, lane k at [32k+31:32k]
//   in_inv     mode for this beat: 0 forward P, 1 inverse P
//   out_valid  output beat present
//   out_ready  downstream accepts the output beat
//   out_data   permuted words, same lane layout as in_data
//   out_inv    mode bit that travelled with the beat
//   busy       any stage holds a valid beat
//   beat_cnt   16-bit wrapping count of output handshakes; present only when
//              P_PERM_STREAM_CNT_EN is defined
module p_perm_stream #(
    parameter int unsigned LANES       = 1,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   in_data,
    input  logic                  in_inv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_data,
    output logic                  out_inv,
    output logic                  busy
`ifdef P_PERM_STREAM_CNT_EN
   ,output logic [15:0]           beat_cnt
`endif
);

    localparam int unsigned Width = 32 * LANES;
    localparam int unsigned Last  = PIPE_STAGES - 1;

    // DES P table, 1-based DES bit numbers (bit 1 = word MSB).
    localparam int unsigned PTab [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // Forward: output DES bit i+1 takes input DES bit PTab[i].
    // Inverse: output DES bit PTab[i] takes input DES bit i+1.
    function automatic logic [31:0] perm_word(input logic [31:0] x, input logic inv);
        logic [31:0] r;
        logic [4:0]  pos_i;
        logic [4:0]  pos_p;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            pos_i = 5'(31 - i);
            pos_p = 5'(32 - PTab[i]);
            if (inv) begin
                r[pos_p] = x[pos_i];
            end else begin
                r[pos_i] = x[pos_p];
            end
        end
        return r;
    endfunction

    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES-1:0] inv_q;
    logic [Width-1:0]       data_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] adv;
    logic [Width-1:0]       perm_data;

    always_comb begin
        perm_data = '0;
        for (int k = 0; k < LANES; k++) begin
            perm_data[32*k +: 32] = perm_word(in_data[32*k +: 32], in_inv);
        end
    end

    // Advance chain built from the output backwards; a running variable keeps
    // the chain free of combinational self-reference on adv.
    always_comb begin
        logic a;
        a = !vld_q[Last] || out_ready;
        adv = '0;
        adv[Last] = a;
        for (int s = int'(PIPE_STAGES) - 2; s >= 0; s--) begin
            a = !vld_q[s] || a;
            adv[s] = a;
        end
    end

    assign in_ready = adv[0] && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            inv_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld_q[0] <= in_valid && in_ready;
                // Only real beats overwrite payload; empty slots keep old data.
                if (in_valid) begin
                    data_q[0] <= perm_data;
                    inv_q[0]  <= in_inv;
                end
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                if (adv[s]) begin
                    vld_q[s] <= vld_q[s-1];
                    if (vld_q[s-1]) begin
                        data_q[s] <= data_q[s-1];
                        inv_q[s]  <= inv_q[s-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld_q[Last];
    assign out_data  = data_q[Last];
    assign out_inv   = inv_q[Last];
    assign busy      = |vld_q;

`ifdef P_PERM_STREAM_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_p_perm_stream.sv
// Scoreboard bench for p_perm_stream (LANES=2, PIPE_STAGES=2). The driver pushes
// expected beats when a handshake is seen; an independent monitor pops and
// compares on every output handshake. Expected words come from a DES-table
// reference model or from known-answer constants.
module tb_p_perm_stream;

    localparam int unsigned LANES  = 2;
    localparam int unsigned STAGES = 2;
    localparam int unsigned W      = 32 * LANES;

    localparam int P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_inv = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_inv;
    logic         busy;
`ifdef P_PERM_STREAM_CNT_EN
    logic [15:0]  beat_cnt;
`endif

    p_perm_stream #(
        .LANES       (LANES),
        .PIPE_STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_inv   (out_inv),
        .busy      (busy)
`ifdef P_PERM_STREAM_CNT_EN
       ,.beat_cnt  (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;  // 0: out_ready=1, 1: random, 2: held low

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        logic         inv;
        int           acc;
        bit           lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: DES bit n (1 = MSB) of x; forward out bit i = in bit P(i);
    // inverse uses the inverted table, out bit j = in bit Pinv(j).
    function automatic logic [31:0] perm_ref(input logic [31:0] x, input bit inv);
        int          pinv [33];
        logic [31:0] r;
        int          src;
        r = '0;
        for (int i = 1; i <= 32; i++) pinv[P[i-1]] = i;
        for (int i = 1; i <= 32; i++) begin
            src = inv ? pinv[i] : P[i-1];
            r = r | (((x >> (32 - src)) & 32'd1) << (32 - i));
        end
        return r;
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input bit inv);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) r[32*k +: 32] = perm_ref(d[32*k +: 32], inv);
        return r;
    endfunction

    // Downstream ready generator, updated on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples 3 time units after the falling edge.
    initial begin
        exp_t         e;
        bit           stall = 0;
        logic [W-1:0] hold_d = '0;
        logic         hold_i = 1'b0;
        logic [15:0]  cnt_m = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                stall = 0;
                cnt_m = '0;
                sb.delete();
            end else begin
                if (stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", 64'(out_data), 64'(hold_d));
                    chk("hold_inv", 64'(out_inv), 64'(hold_i));
                end
`ifdef P_PERM_STREAM_CNT_EN
                chk("beat_cnt", 64'(beat_cnt), 64'(cnt_m));
`endif
                if (out_valid && out_ready) begin
                    cnt_m = cnt_m + 16'd1;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h expected no beat", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 64'(out_data), 64'(e.data));
                        chk("out_inv", 64'(out_inv), 64'(e.inv));
                        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
                    end
                end
                stall  = out_valid && !out_ready;
                hold_d = out_data;
                hold_i = out_inv;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_mode(input int m);
        rdy_mode = m;
        tick();
    endtask

    // One attempt: present the beat for one cycle, push expectation on accept.
    task automatic try_send(input logic [W-1:0] d, input bit m, input logic [W-1:0] e,
                            output bit ok);
        exp_t x;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = m;
        #2;
        ok = in_ready;
        if (ok) begin
            x.data = e;
            x.inv  = m;
            x.acc  = cyc;
            x.lat  = (rdy_mode == 0) && out_ready;
            sb.push_back(x);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input bit m, input logic [W-1:0] e,
                        output int tries);
        bit ok;
        tries = 0;
        ok = 0;
        while (!ok && tries < 1000) begin
            try_send(d, m, e, ok);
            tries++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 1000 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int           tries;
        int           acc;
        bit           ok;
        logic [W-1:0] d;
        logic [W-1:0] t;
        bit           m;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("in_ready_in_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_inv", 64'(out_inv), 64'd0);
        tick();

        // Known-answer beats, back to back with out_ready high
        send({32'h43886112, 32'hC842AFFB}, 0, {32'h4206E1C0, 32'h1BFBAC89}, tries);
        chk("stream_accept", 64'(tries), 64'd1);
        send({32'h98C36FAF, 32'h94BE923C}, 0, {32'h98EF2DAB, 32'h2FE01576}, tries);
        chk("stream_accept", 64'(tries), 64'd1);
        send({32'h727AFC43, 32'h98C36FAF}, 0, {32'h75578ACE, 32'h98EF2DAB}, tries);
        chk("stream_accept", 64'(tries), 64'd1);
        send({32'h1ADF97F6, 32'h1ADF97F6}, 1, {32'hFCEE687E, 32'hFCEE687E}, tries);
        d = {32'h7CE5B191, 32'h7CE5B191};
        t = model(d, 0);
        send(d, 0, t, tries);
        send(t, 1, d, tries);
        drain();

        // Backpressure: out_ready low, pipeline fills with exactly STAGES beats
        set_mode(2);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            d = {$urandom(), $urandom()};
            m = 1'($urandom_range(0, 1));
            try_send(d, m, model(d, m), ok);
            if (ok) acc++;
        end
        chk("bp_accepts", 64'(acc), 64'(STAGES));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        set_mode(0);
        for (int i = 0; i < 4; i++) begin
            d = {$urandom(), $urandom()};
            m = 1'($urandom_range(0, 1));
            send(d, m, model(d, m), tries);
        end
        drain();

        // Reset with two beats in flight
        set_mode(2);
        for (int i = 0; i < 2; i++) begin
            d = {$urandom(), $urandom()};
            send(d, 0, model(d, 0), tries);
        end
        rst = 1'b1;
        #2;
        chk("in_ready_in_rst2", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_out_data", 64'(out_data), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
`ifdef P_PERM_STREAM_CNT_EN
        chk("flush_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
        set_mode(0);
        repeat (6) tick();

        // Randomised traffic with random downstream stalls
        set_mode(1);
        for (int i = 0; i < 300; i++) begin
            d = {$urandom(), $urandom()};
            m = 1'($urandom_range(0, 1));
            send(d, m, model(d, m), tries);
            if ($urandom_range(0, 3) == 0) tick();
        end
        set_mode(0);
        drain();

`ifdef P_PERM_STREAM_CNT_EN
        // Counter wrap after 65536 handshakes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 65536; i++) begin
            d = {$urandom(), $urandom()};
            send(d, 0, model(d, 0), tries);
        end
        drain();
        chk("beat_cnt_wrap", 64'(beat_cnt), 64'd0);
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
